// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: takes one AC snoop at a time, queries the local
// tag/data array, answers on CR/CD and writes back any resulting line-state change.
package ace_snoop_responder_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic        ac_valid;
    ac_chan_t    ac;
    logic        cr_ready;
    logic        cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic        ac_ready;
    logic        cr_valid;
    logic [4:0]  cr_resp;
    logic        cd_valid;
    cd_chan_t    cd;
  } snoop_resp_t;
endpackage

module ace_snoop_responder #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 512,
  parameter type snoop_req_t  = ace_snoop_responder_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_responder_pkg::snoop_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  snoop_req_t           snoop_req_i,
  output snoop_resp_t          snoop_resp_o,
  output logic                 lu_valid_o,
  input  logic                 lu_ready_i,
  output logic [AddrWidth-1:0] lu_addr_o,
  input  logic                 lu_rvalid_i,
  input  logic                 lu_hit_i,
  input  logic [2:0]           lu_state_i,
  input  logic [LineWidth-1:0] lu_line_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [AddrWidth-1:0] upd_addr_o,
  output logic [2:0]           upd_state_o
);
  localparam int unsigned NumBeats = LineWidth / DataWidth;
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned OffW     = $clog2(LineWidth / 8);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WAIT, S_RESP, S_DATA, S_UPDATE
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [3:0]             snoop_q, snoop_d;
  logic [LineWidth-1:0]   line_q, line_d;
  logic                   dt_q, dt_d;
  logic                   upd_need_q, upd_need_d;
  logic [2:0]             new_state_q, new_state_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic                   ac_ready_q, ac_ready_d;
  logic                   lu_valid_q, lu_valid_d;
  logic [AddrWidth-1:0]   lu_addr_q, lu_addr_d;
  logic                   cr_valid_q, cr_valid_d;
  logic [4:0]             cr_resp_q, cr_resp_d;
  logic                   cd_valid_q, cd_valid_d;
  logic [DataWidth-1:0]   cd_data_q, cd_data_d;
  logic                   cd_last_q, cd_last_d;
  logic                   upd_valid_q, upd_valid_d;
  logic [AddrWidth-1:0]   upd_addr_q, upd_addr_d;
  logic [2:0]             upd_state_q, upd_state_d;

  logic [AddrWidth-1:0]   ac_addr_aligned;
  logic                   lu_present;
  logic                   dec_sup, dec_dt, dec_pd, dec_is, dec_wu;
  logic [2:0]             dec_ns;
  logic [DataWidth-1:0]   line_beats [NumBeats];

  logic unused_ok;
  assign unused_ok = ^{snoop_req_i.ac.prot, snoop_req_i.ac.addr[OffW-1:0]};

  assign ac_addr_aligned = {snoop_req_i.ac.addr[AddrWidth-1:OffW], {OffW{1'b0}}};
  assign lu_present      = lu_hit_i && lu_state_i[2];

  for (genvar gi = 0; gi < NumBeats; gi++) begin : g_beats
    assign line_beats[gi] = line_q[gi*DataWidth +: DataWidth];
  end

  // Response bits and next line state for a hit; lu_state_i = {valid, unique, dirty}.
  always_comb begin
    dec_sup = 1'b1;
    dec_dt  = 1'b0;
    dec_pd  = 1'b0;
    dec_is  = 1'b0;
    dec_wu  = lu_state_i[1];
    dec_ns  = lu_state_i;
    case (snoop_q)
      4'b0000: begin
        dec_dt = 1'b1;
        dec_is = 1'b1;
      end
      4'b0001, 4'b0010, 4'b0011: begin
        dec_dt = 1'b1;
        dec_is = 1'b1;
        dec_pd = lu_state_i[0];
        dec_ns = 3'b100;
      end
      4'b0111: begin
        dec_dt = 1'b1;
        dec_pd = lu_state_i[0];
        dec_ns = 3'b000;
      end
      4'b1001: begin
        dec_dt = lu_state_i[0];
        dec_pd = lu_state_i[0];
        dec_ns = 3'b000;
      end
      4'b1101: dec_ns = 3'b000;
      4'b1000: begin
        dec_dt = lu_state_i[0];
        dec_pd = lu_state_i[0];
        dec_is = 1'b1;
        dec_ns = {1'b1, lu_state_i[1], 1'b0};
      end
      default: dec_sup = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    line_d      = line_q;
    dt_d        = dt_q;
    upd_need_d  = upd_need_q;
    new_state_d = new_state_q;
    beat_d      = beat_q;
    lu_addr_d   = lu_addr_q;
    cr_resp_d   = cr_resp_q;
    cd_data_d   = cd_data_q;
    cd_last_d   = cd_last_q;
    upd_addr_d  = upd_addr_q;
    upd_state_d = upd_state_q;

    case (state_q)
      S_IDLE: begin
        if (snoop_req_i.ac_valid && ac_ready_q) begin
          addr_d    = ac_addr_aligned;
          lu_addr_d = ac_addr_aligned;
          snoop_d   = snoop_req_i.ac.snoop;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lu_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lu_rvalid_i) begin
          line_d      = lu_line_i;
          new_state_d = dec_ns;
          if (!dec_sup) begin
            cr_resp_d  = 5'b00010;
            dt_d       = 1'b0;
            upd_need_d = 1'b0;
          end else if (!lu_present) begin
            cr_resp_d  = 5'b00000;
            dt_d       = 1'b0;
            upd_need_d = 1'b0;
          end else begin
            cr_resp_d  = {dec_wu, dec_is, dec_pd, 1'b0, dec_dt};
            dt_d       = dec_dt;
            upd_need_d = (dec_ns != lu_state_i);
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (snoop_req_i.cr_ready) begin
          if (dt_q) begin
            beat_d    = '0;
            cd_data_d = line_beats[0];
            cd_last_d = (LastBeat == '0);
            state_d   = S_DATA;
          end else if (upd_need_q) begin
            upd_addr_d  = addr_q;
            upd_state_d = new_state_q;
            state_d     = S_UPDATE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (snoop_req_i.cd_ready) begin
          if (beat_q == LastBeat) begin
            beat_d = '0;
            if (upd_need_q) begin
              upd_addr_d  = addr_q;
              upd_state_d = new_state_q;
              state_d     = S_UPDATE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            beat_d    = beat_q + 1'b1;
            cd_data_d = line_beats[beat_d];
            cd_last_d = (beat_d == LastBeat);
          end
        end
      end
      S_UPDATE: begin
        if (upd_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of "which state are we entering".
    ac_ready_d  = (state_d == S_IDLE);
    lu_valid_d  = (state_d == S_LOOKUP);
    cr_valid_d  = (state_d == S_RESP);
    cd_valid_d  = (state_d == S_DATA);
    upd_valid_d = (state_d == S_UPDATE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      snoop_q     <= '0;
      line_q      <= '0;
      dt_q        <= 1'b0;
      upd_need_q  <= 1'b0;
      new_state_q <= '0;
      beat_q      <= '0;
      ac_ready_q  <= 1'b0;
      lu_valid_q  <= 1'b0;
      lu_addr_q   <= '0;
      cr_valid_q  <= 1'b0;
      cr_resp_q   <= '0;
      cd_valid_q  <= 1'b0;
      cd_data_q   <= '0;
      cd_last_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_addr_q  <= '0;
      upd_state_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      snoop_q     <= snoop_d;
      line_q      <= line_d;
      dt_q        <= dt_d;
      upd_need_q  <= upd_need_d;
      new_state_q <= new_state_d;
      beat_q      <= beat_d;
      ac_ready_q  <= ac_ready_d;
      lu_valid_q  <= lu_valid_d;
      lu_addr_q   <= lu_addr_d;
      cr_valid_q  <= cr_valid_d;
      cr_resp_q   <= cr_resp_d;
      cd_valid_q  <= cd_valid_d;
      cd_data_q   <= cd_data_d;
      cd_last_q   <= cd_last_d;
      upd_valid_q <= upd_valid_d;
      upd_addr_q  <= upd_addr_d;
      upd_state_q <= upd_state_d;
    end
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = ac_ready_q;
    snoop_resp_o.cr_valid = cr_valid_q;
    snoop_resp_o.cr_resp  = cr_resp_q;
    snoop_resp_o.cd_valid = cd_valid_q;
    snoop_resp_o.cd.data  = cd_data_q;
    snoop_resp_o.cd.last  = cd_last_q;
  end

  assign lu_valid_o  = lu_valid_q;
  assign lu_addr_o   = lu_addr_q;
  assign upd_valid_o = upd_valid_q;
  assign upd_addr_o  = upd_addr_q;
  assign upd_state_o = upd_state_q;
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed table vectors plus stall, reset-abort and spurious-result sequences
// for ace_snoop_responder; inputs change and outputs are sampled on the falling edge.
module tb_ace_snoop_responder;
  import ace_snoop_responder_pkg::*;

  logic          clk = 1'b0;
  logic          rst_ni;
  snoop_req_t    req;
  snoop_resp_t   resp;
  logic          lu_valid, lu_ready, lu_rvalid, lu_hit;
  logic [63:0]   lu_addr;
  logic [2:0]    lu_state;
  logic [511:0]  lu_line;
  logic          upd_valid, upd_ready;
  logic [63:0]   upd_addr;
  logic [2:0]    upd_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ace_snoop_responder dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .snoop_req_i  (req),
    .snoop_resp_o (resp),
    .lu_valid_o   (lu_valid),
    .lu_ready_i   (lu_ready),
    .lu_addr_o    (lu_addr),
    .lu_rvalid_i  (lu_rvalid),
    .lu_hit_i     (lu_hit),
    .lu_state_i   (lu_state),
    .lu_line_i    (lu_line),
    .upd_valid_o  (upd_valid),
    .upd_ready_i  (upd_ready),
    .upd_addr_o   (upd_addr),
    .upd_state_o  (upd_state)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input logic [63:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
    return l;
  endfunction

  // One complete snoop; enters and leaves on a falling edge.
  task automatic do_snoop(input logic [3:0] snp, input logic [63:0] addr, input logic hit,
                          input logic [2:0] st, input logic [511:0] line, input bit stall,
                          input logic [4:0] exp_resp, input int exp_beats, input bit exp_upd,
                          input logic [2:0] exp_ust, input int abort_beat);
    int cyc;
    int beats;
    int dly;
    bit upd_seen;
    bit r;
    bit hs_cd;
    logic [63:0] al;
    al = {addr[63:6], 6'd0};
    req.ac_valid = 1'b1;
    req.ac.addr  = addr;
    req.ac.snoop = snp;
    req.ac.prot  = 3'b010;
    cyc = 0;
    while (resp.ac_ready !== 1'b1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 50) begin
        chk("ac_timeout", 64'(0), 64'(1));
        req.ac_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    req.ac_valid = 1'b0;
    req.ac.addr  = '1;
    req.ac.snoop = 4'b1111;
    chk("busy_ac_ready", 64'(resp.ac_ready), 64'(0));
    cyc = 0;
    forever begin
      chk("lu_valid", 64'(lu_valid), 64'(1));
      chk("lu_addr", lu_addr, al);
      r = (stall && cyc < 20) ? ($urandom_range(0, 2) != 0) : 1'b1;
      lu_ready = r;
      @(negedge clk);
      lu_ready = 1'b0;
      cyc++;
      if (r) break;
    end
    chk("lu_valid_drop", 64'(lu_valid), 64'(0));
    dly = stall ? $urandom_range(0, 3) : 0;
    repeat (dly) begin
      chk("cr_early", 64'(resp.cr_valid), 64'(0));
      @(negedge clk);
    end
    lu_rvalid = 1'b1;
    lu_hit    = hit;
    lu_state  = st;
    lu_line   = line;
    @(negedge clk);
    lu_rvalid = 1'b0;
    lu_hit    = ~hit;
    lu_state  = ~st;
    lu_line   = ~line;
    cyc = 0;
    forever begin
      chk("cr_valid", 64'(resp.cr_valid), 64'(1));
      chk("cr_resp", 64'(resp.cr_resp), 64'(exp_resp));
      r = (stall && cyc < 20) ? ($urandom_range(0, 2) != 0) : 1'b1;
      req.cr_ready = r;
      @(negedge clk);
      req.cr_ready = 1'b0;
      cyc++;
      if (r) break;
    end
    if (exp_beats > 0) chk("cd_after_cr", 64'(resp.cd_valid), 64'(1));
    else if (exp_upd) chk("upd_after_cr", 64'(upd_valid), 64'(1));
    else chk("idle_after_cr", 64'(resp.ac_ready), 64'(1));
    beats = 0;
    upd_seen = 1'b0;
    cyc = 0;
    forever begin
      if (resp.cd_valid) begin
        chk("cd_data", resp.cd.data, line[(beats % 8)*64 +: 64]);
        chk("cd_last", 64'(resp.cd.last), 64'(beats == exp_beats - 1));
        if (beats == abort_beat) begin
          rst_ni = 1'b0;
          @(negedge clk);
          chk("rst_cd_valid", 64'(resp.cd_valid), 64'(0));
          chk("rst_upd_valid", 64'(upd_valid), 64'(0));
          chk("rst_cr_valid", 64'(resp.cr_valid), 64'(0));
          chk("rst_ac_ready", 64'(resp.ac_ready), 64'(0));
          rst_ni = 1'b1;
          @(negedge clk);
          chk("rel_ac_ready", 64'(resp.ac_ready), 64'(1));
          repeat (3) begin
            chk("rel_no_upd", 64'(upd_valid), 64'(0));
            chk("rel_no_cd", 64'(resp.cd_valid), 64'(0));
            @(negedge clk);
          end
          return;
        end
        req.cd_ready = (stall && cyc < 100) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (upd_valid) begin
        chk("upd_state", 64'(upd_state), 64'(exp_ust));
        chk("upd_addr", upd_addr, al);
        upd_ready = (stall && cyc < 100) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (!resp.cd_valid && !upd_valid) begin
        chk("idle_return", 64'(resp.ac_ready), 64'(1));
        break;
      end
      @(negedge clk);
      hs_cd = req.cd_ready;
      if (req.cd_ready) beats++;
      if (upd_ready) upd_seen = 1'b1;
      req.cd_ready = 1'b0;
      upd_ready    = 1'b0;
      if (hs_cd && beats == exp_beats)
        chk("after_last", 64'(exp_upd ? upd_valid : resp.ac_ready), 64'(1));
      cyc++;
      if (cyc > 300) begin
        chk("post_cr_timeout", 64'(0), 64'(1));
        break;
      end
    end
    chk("beat_count", 64'(beats), 64'(exp_beats));
    chk("upd_issued", 64'(upd_seen), 64'(exp_upd));
  endtask

  typedef struct {
    logic [3:0] snp;
    logic       hit;
    logic [2:0] st;
    logic [4:0] resp;
    int         beats;
    bit         upd;
    logic [2:0] ust;
  } vec_t;

  vec_t vt[14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  snp;
    logic        hit;
    logic [2:0]  st;
    logic [4:0]  er;
    int          eb;
    bit          eu;

    vt[0]  = '{4'b0001, 1'b1, 3'b111, 5'b11101, 8, 1'b1, 3'b100};
    vt[1]  = '{4'b0111, 1'b0, 3'b111, 5'b00000, 0, 1'b0, 3'b000};
    vt[2]  = '{4'b1001, 1'b1, 3'b100, 5'b00000, 0, 1'b1, 3'b000};
    vt[3]  = '{4'b1001, 1'b1, 3'b111, 5'b10101, 8, 1'b1, 3'b000};
    vt[4]  = '{4'b1110, 1'b1, 3'b111, 5'b00010, 0, 1'b0, 3'b000};
    vt[5]  = '{4'b0000, 1'b1, 3'b110, 5'b11001, 8, 1'b0, 3'b000};
    vt[6]  = '{4'b0010, 1'b1, 3'b101, 5'b01101, 8, 1'b1, 3'b100};
    vt[7]  = '{4'b0011, 1'b1, 3'b100, 5'b01001, 8, 1'b0, 3'b000};
    vt[8]  = '{4'b1101, 1'b1, 3'b111, 5'b10000, 0, 1'b1, 3'b000};
    vt[9]  = '{4'b1000, 1'b1, 3'b111, 5'b11101, 8, 1'b1, 3'b110};
    vt[10] = '{4'b1000, 1'b1, 3'b110, 5'b11000, 0, 1'b0, 3'b000};
    vt[11] = '{4'b0001, 1'b1, 3'b011, 5'b00000, 0, 1'b0, 3'b000};
    vt[12] = '{4'b0111, 1'b1, 3'b100, 5'b00001, 8, 1'b1, 3'b000};
    vt[13] = '{4'b1101, 1'b0, 3'b111, 5'b00000, 0, 1'b0, 3'b000};

    rst_ni    = 1'b0;
    req       = '0;
    lu_ready  = 1'b0;
    lu_rvalid = 1'b0;
    lu_hit    = 1'b0;
    lu_state  = '0;
    lu_line   = '0;
    upd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ac_ready", 64'(resp.ac_ready), 64'(0));
    chk("rst_lu_valid", 64'(lu_valid), 64'(0));
    chk("rst_cr_valid", 64'(resp.cr_valid), 64'(0));
    chk("rst_cd_valid", 64'(resp.cd_valid), 64'(0));
    chk("rst_upd_valid", 64'(upd_valid), 64'(0));
    chk("rst_cr_resp", 64'(resp.cr_resp), 64'(0));
    chk("rst_cd_data", resp.cd.data, 64'(0));
    chk("rst_lu_addr", lu_addr, 64'(0));
    chk("rst_upd_addr", upd_addr, 64'(0));
    chk("rst_upd_state", 64'(upd_state), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ac_ready_after_rst", 64'(resp.ac_ready), 64'(1));

    for (int i = 0; i < 14; i++) begin
      do_snoop(vt[i].snp, 64'h0000_1234_5678_9000 + 64'(i * 64) + 64'(i), vt[i].hit, vt[i].st,
               make_line(64'h1000 + 64'(i * 16'h100)), 1'b0, vt[i].resp, vt[i].beats,
               vt[i].upd, vt[i].ust, -1);
      $display("vector %0d snoop=%b state=%b done: total=%0d bad=%0d",
               i, vt[i].snp, vt[i].st, total, bad);
    end

    lu_rvalid = 1'b1;
    lu_hit    = 1'b1;
    lu_state  = 3'b111;
    @(negedge clk);
    lu_rvalid = 1'b0;
    repeat (3) begin
      chk("spurious_cr", 64'(resp.cr_valid), 64'(0));
      chk("spurious_ac_ready", 64'(resp.ac_ready), 64'(1));
      @(negedge clk);
    end
    $display("spurious lookup result in idle: total=%0d bad=%0d", total, bad);

    do_snoop(4'b0001, 64'h0000_0000_0000_4040, 1'b1, 3'b111, make_line(64'h1000), 1'b0,
             5'b11101, 8, 1'b1, 3'b100, 3);
    $display("reset during data beat 3: total=%0d bad=%0d", total, bad);
    do_snoop(4'b0001, 64'h0000_0000_0000_8080, 1'b1, 3'b111, make_line(64'h1000), 1'b0,
             5'b11101, 8, 1'b1, 3'b100, -1);
    $display("snoop after reset recovery: total=%0d bad=%0d", total, bad);

    for (int n = 0; n < 1000; n++) begin
      snp = ($urandom_range(0, 1) != 0) ? 4'b0001 : 4'b0000;
      hit = ($urandom_range(0, 7) != 0);
      st  = 3'($urandom_range(0, 7));
      if (!(hit && st[2])) begin
        er = 5'b00000;
        eb = 0;
        eu = 1'b0;
      end else if (snp == 4'b0000) begin
        er = {st[1], 1'b1, 1'b0, 1'b0, 1'b1};
        eb = 8;
        eu = 1'b0;
      end else begin
        er = {st[1], 1'b1, st[0], 1'b0, 1'b1};
        eb = 8;
        eu = (st != 3'b100);
      end
      do_snoop(snp, {$urandom, $urandom}, hit, st, make_line({$urandom, $urandom}), 1'b1,
               er, eb, eu, 3'b100, -1);
      $display("stall snoop %0d snoop=%b hit=%b state=%b: total=%0d bad=%0d",
               n, snp, hit, st, total, bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
